// File: rtl/psum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_accumulator_pkg
//  Description : Shared convolution datapath widths. The saturation stage
//                imports the same package, so its input width always equals
//                the accumulator width.
//  Revision    : 1.0  initial release
// ============================================================================
package psum_accumulator_pkg;

    localparam int PSUM_BW    = 21;   // accumulator / saturation input width
    localparam int OSUM_BW    = 16;   // saturation output width
    localparam int PROD_BW    = 16;   // signed kernel x channel product width
    localparam int LEN_BW_DEF = 8;    // default group-length field width

    typedef logic signed [PSUM_BW-1:0] psum_t;

endpackage
`default_nettype wire

// File: rtl/psum_accumulator_add_ovf.sv
`default_nettype none
// ============================================================================
//  Module      : psum_add_ovf
//  Description : Combinational W-bit two's-complement adder with a signed
//                overflow flag. Overflow is flagged when both operands share
//                a sign and the truncated sum has the other sign.
//  Ports       : i_a, i_b  W-bit signed operands
//                o_sum     W-bit wrapped sum
//                o_ovf     signed overflow of this add
//  Revision    : 1.0  initial release
// ============================================================================
module psum_add_ovf
    import psum_accumulator_pkg::*;
#(
    parameter int W = PSUM_BW
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    assign o_sum = i_a + i_b;
    assign o_ovf = (i_a[W-1] == i_b[W-1]) && (o_sum[W-1] != i_a[W-1]);

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : psum_accumulator
//  Description : Accumulates a stream of signed partial products into one
//                signed partial sum per group (output pixel). The group
//                length and the bias are sampled on the first beat of each
//                group. The result sits in an output register with its own
//                valid/ready handshake so the next group can fill while the
//                result waits to drain.
//  Ports       : clk        clock, rising edge
//                reset      asynchronous, active-high reset
//                i_acc_len  beats per group (0 behaves as 1)
//                i_bias     signed per-group bias
//                s_valid / s_ready / s_data   input product stream
//                m_valid / m_ready            result handshake
//                m_psum     wrapped signed group sum
//                m_ovf      any add in the group overflowed
//  Revision    : 1.0  initial release
// ============================================================================
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int IN_BW  = PROD_BW,
    parameter int ACC_BW = PSUM_BW,
    parameter int LEN_BW = LEN_BW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_BW-1:0] i_acc_len,
    input  logic [ACC_BW-1:0] i_bias,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_BW-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_BW-1:0] m_psum,
    output logic              m_ovf
);

    localparam logic [LEN_BW-1:0] c_len_zero = '0;
    localparam logic [LEN_BW-1:0] c_len_one  = {{(LEN_BW-1){1'b0}}, 1'b1};

    // Accumulation state; r_cnt == 0 means "waiting for the first beat".
    logic [LEN_BW-1:0] r_cnt;
    logic [LEN_BW-1:0] r_len;
    logic [ACC_BW-1:0] r_acc;
    logic              r_ovf;

    logic              w_first;
    logic [LEN_BW-1:0] w_len_eff;
    logic              w_is_last;
    logic              w_beat;
    logic [ACC_BW-1:0] w_data_ext;
    logic [ACC_BW-1:0] w_addend;
    logic [ACC_BW-1:0] w_sum;
    logic              w_add_ovf;

    assign w_first   = (r_cnt == c_len_zero);
    assign w_len_eff = (i_acc_len == c_len_zero) ? c_len_one : i_acc_len;

    // Position-only last-beat decode: depends on the count and lengths, never
    // on s_valid, so s_ready has no combinational path from s_valid.
    assign w_is_last = w_first ? (w_len_eff == c_len_one)
                               : (r_cnt == (r_len - c_len_one));

    // Only a final beat needs the output register; it must wait while an
    // undrained result is held. Non-final beats always proceed.
    assign s_ready = !(w_is_last && m_valid && !m_ready);
    assign w_beat  = s_valid && s_ready;

    assign w_data_ext = {{(ACC_BW-IN_BW){s_data[IN_BW-1]}}, s_data};
    assign w_addend   = w_first ? i_bias : r_acc;

    psum_add_ovf #(
        .W (ACC_BW)
    ) u_add (
        .i_a   (w_addend),
        .i_b   (w_data_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_len <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            if (w_first) begin
                r_len <= w_len_eff;
            end
            if (w_is_last) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_cnt <= r_cnt + c_len_one;
                r_acc <= w_sum;
                // r_ovf is already clear on the first beat of a group.
                r_ovf <= r_ovf | w_add_ovf;
            end
        end
    end

    // Output register. A new result may load in the same cycle the old one
    // drains, in which case m_valid simply stays high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_psum  <= '0;
            m_ovf   <= 1'b0;
        end else if (w_beat && w_is_last) begin
            m_valid <= 1'b1;
            m_psum  <= w_sum;
            m_ovf   <= r_ovf | w_add_ovf;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_accumulator
//  Description : Self-checking bench for psum_accumulator. Accepted beats feed
//                an arithmetic group model that pushes expected results into
//                a queue; an independent monitor pops and compares on every
//                output handshake and checks output stability under stall.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psum_accumulator;

    localparam int IN_BW  = 16;
    localparam int ACC_BW = 21;
    localparam int LEN_BW = 8;
    localparam longint c_acc_min = -(64'sd1 <<< (ACC_BW-1));
    localparam longint c_acc_max =  (64'sd1 <<< (ACC_BW-1)) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [LEN_BW-1:0] i_acc_len = '0;
    logic [ACC_BW-1:0] i_bias = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [IN_BW-1:0]  s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [ACC_BW-1:0] m_psum;
    logic              m_ovf;

    psum_accumulator #(
        .IN_BW  (IN_BW),
        .ACC_BW (ACC_BW),
        .LEN_BW (LEN_BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_acc_len (i_acc_len),
        .i_bias    (i_bias),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_psum    (m_psum),
        .m_ovf     (m_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint psum;
        bit     ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     in_reset = 1'b1;
    bit     rand_mready = 1'b0;

    // Reference group model: exact integer arithmetic, wrapped to ACC_BW.
    int     grp_cnt = 0;
    int     grp_len = 0;
    longint grp_acc = 0;
    bit     grp_ovf = 1'b0;

    function automatic longint wrap_acc(input longint x);
        longint m;
        m = x & ((64'sd1 <<< ACC_BW) - 1);
        if (m > c_acc_max) m = m - (64'sd1 <<< ACC_BW);
        return m;
    endfunction

    task automatic model_accept(input int len, input int bias, input int data);
        longint exact;
        exp_t   e;
        if (grp_cnt == 0) begin
            grp_len = (len == 0) ? 1 : len;
            exact   = longint'(bias) + longint'(data);
        end else begin
            exact   = grp_acc + longint'(data);
        end
        if (exact < c_acc_min || exact > c_acc_max) grp_ovf = 1'b1;
        grp_acc = wrap_acc(exact);
        grp_cnt++;
        if (grp_cnt == grp_len) begin
            e.psum = grp_acc;
            e.ovf  = grp_ovf;
            exp_q.push_back(e);
            grp_cnt = 0;
            grp_acc = 0;
            grp_ovf = 1'b0;
        end
    endtask

    task automatic check1(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int len, input int bias, input int data);
        int waited;
        waited = 0;
        @(negedge clk);
        s_valid   = 1'b1;
        i_acc_len = len[LEN_BW-1:0];
        i_bias    = bias[ACC_BW-1:0];
        s_data    = data[IN_BW-1:0];
        #1;
        while (!s_ready) begin
            waited++;
            if (waited > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        model_accept(len, bias, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid  = 1'b0;
        in_reset = 1'b1;
        reset    = 1'b1;
        #1;
        check1("rst_m_valid", longint'(m_valid), 0);
        check1("rst_m_psum",  longint'(m_psum), 0);
        check1("rst_m_ovf",   longint'(m_ovf), 0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_q.delete();
        grp_cnt = 0;
        grp_acc = 0;
        grp_ovf = 1'b0;
        #1;
        check1("rst_s_ready", longint'(s_ready), 1);
        in_reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks that
    // a stalled result does not change.
    initial begin
        bit                prev_stall;
        logic [ACC_BW-1:0] hold_psum;
        logic              hold_ovf;
        exp_t              e;
        prev_stall = 1'b0;
        hold_psum  = '0;
        hold_ovf   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (m_psum !== hold_psum || m_ovf !== hold_ovf) begin
                        errors++;
                        $display("FAIL stall_hold actual=%0d/%0b required=%0d/%0b",
                                 $signed(m_psum), m_ovf, $signed(hold_psum), hold_ovf);
                    end
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%0d required=none",
                                 $signed(m_psum));
                    end else begin
                        e = exp_q.pop_front();
                        check1("sb_psum", longint'($signed(m_psum)), e.psum);
                        check1("sb_ovf",  longint'(m_ovf), longint'(e.ovf));
                    end
                end
                prev_stall = m_valid && !m_ready;
                hold_psum  = m_psum;
                hold_ovf   = m_ovf;
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_mready) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int len;
        int eff;
        int bias;
        int data;
        int l;

        do_reset();

        // Basic group: 1+2+3+4 = 10, result one cycle after the last beat.
        m_ready = 1'b1;
        send(4, 0, 1);
        send(4, 0, 2);
        send(4, 0, 3);
        send(4, 0, 4);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        check1("latency_m_valid", longint'(m_valid), 1);
        check1("t1_psum", longint'($signed(m_psum)), 10);
        idle(2);

        // Negative bias, then a single-beat group back-to-back.
        send(3, -5, -1);
        send(3, -5, -1);
        send(3, -5, -1);
        send(1, 7, 3);
        idle(3);

        // Large sums without overflow, then a forced wrap.
        for (int i = 0; i < 32; i++) send(32, 0, 32767);
        send(2, 1048575, 0);
        send(2, 0, 1);
        idle(3);

        // Stalled output: non-final beats proceed, final beat waits.
        send(1, 0, 100);
        m_ready = 1'b0;
        send(3, 0, 1);
        send(3, 0, 2);
        @(negedge clk);
        s_valid   = 1'b1;
        i_acc_len = 8'd3;
        i_bias    = '0;
        s_data    = 16'd3;
        #1;
        check1("stall_s_ready", longint'(s_ready), 0);
        check1("stall_m_valid", longint'(m_valid), 1);
        m_ready = 1'b1;
        #1;
        check1("release_s_ready", longint'(s_ready), 1);
        model_accept(3, 0, 3);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        check1("reload_m_valid", longint'(m_valid), 1);
        idle(3);

        // Reset mid-group discards the partial sum.
        send(4, 0, 50);
        send(4, 0, 60);
        do_reset();
        send(2, 0, 5);
        send(2, 0, 6);
        idle(3);

        // Zero length acts as one; mid-group length changes are ignored.
        send(0, 4, 9);
        send(3, 10, 1);
        send(1, 99, 2);
        send(0, 99, 3);
        idle(3);

        // Randomized groups with random gaps and backpressure.
        rand_mready = 1'b1;
        for (int g = 0; g < 80; g++) begin
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 40))
                                              : int'($urandom_range(0, 5));
            eff = (len == 0) ? 1 : len;
            for (int b = 0; b < eff; b++) begin
                l    = (b == 0) ? len : int'($urandom_range(0, 255));
                bias = ($urandom_range(0, 3) == 0)
                     ? int'($urandom_range(0, 2097151)) - 1048576
                     : int'($urandom_range(0, 2000)) - 1000;
                data = int'($urandom_range(0, 65535)) - 32768;
                send(l, bias, data);
                if ($urandom_range(0, 4) == 0) idle(1);
            end
        end
        idle(1);
        rand_mready = 1'b0;
        m_ready     = 1'b1;
        idle(6);
        check1("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
